// File: rtl/qam_pkg.sv
// qam_pkg: shared widths, level codes, cosine table and level decoder for
// the 16-QAM carrier mixer.
package qam_pkg;

  localparam int AMP_W  = 8;
  localparam int OUT_W  = 12;
  localparam int LVL_W  = 3;
  localparam int PROD_W = LVL_W + AMP_W;

  localparam logic [LVL_W-1:0] LVL_P1 = 3'b001;
  localparam logic [LVL_W-1:0] LVL_P3 = 3'b011;
  localparam logic [LVL_W-1:0] LVL_M3 = 3'b101;
  localparam logic [LVL_W-1:0] LVL_M1 = 3'b111;

  typedef logic signed [LVL_W-1:0] level_t;
  typedef logic signed [AMP_W-1:0] amp_t;

  typedef struct packed {
    logic   legal;
    level_t level;
  } level_dec_t;

  // round(127*cos(2*pi*k/16)), k = 0..15
  localparam amp_t COS_LUT [16] = '{
    8'sd127,  8'sd117,  8'sd90,   8'sd49,
    8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
   -8'sd127, -8'sd117, -8'sd90,  -8'sd49,
    8'sd0,    8'sd49,   8'sd90,   8'sd117
  };

  // The legal codes already are the two's complement of their level, so a
  // legal code passes straight through and anything else becomes level 0.
  function automatic level_dec_t decode_level(input logic [LVL_W-1:0] code);
    level_dec_t d;
    d.legal = 1'b0;
    d.level = '0;
    case (code)
      LVL_P1, LVL_P3, LVL_M3, LVL_M1: begin
        d.legal = 1'b1;
        d.level = level_t'(code);
      end
      default: begin
        d.legal = 1'b0;
        d.level = '0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/qam_carrier_lut.sv
// qam_carrier_lut: registered cosine/sine ROM. Given the phase index it
// returns cos and sin amplitudes one clock later; sin is the cosine table
// read a quarter period (4 entries) behind.
module qam_carrier_lut
  import qam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] idx,
  output amp_t       cos_v,
  output amp_t       sin_v
);

  amp_t       cos_d, cos_q;
  amp_t       sin_d, sin_q;
  logic [3:0] sin_idx;

  // Table lookup; the 4-bit subtraction wraps the sine index mod 16.
  always_comb begin
    sin_idx = idx - 4'd4;
    cos_d   = COS_LUT[idx];
    sin_d   = COS_LUT[sin_idx];
  end

  // Output registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_v = cos_q;
  assign sin_v = sin_q;

endmodule

// File: rtl/qam_carrier_mixer.sv
// qam_carrier_mixer: mixes latched I/Q levels onto a LUT carrier,
// qam_out = a*cos(wt) - b*sin(wt), through a 3-stage free-running pipeline.
// Optional build macro QAM_PHASE_SYNC_EN: when defined, every symbol strobe
// restarts the carrier at phase 0; otherwise the phase runs continuously.
module qam_carrier_mixer
  import qam_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int PHASE_INC = 16
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sym_stb,
  input  logic [2:0]              Siga,
  input  logic [2:0]              Sigb,
  output logic signed [OUT_W-1:0] qam_out,
  output logic                    out_valid,
  output logic [3:0]              phase_idx,
  output logic                    lvl_err
);

  level_dec_t dec_a, dec_b;

  logic [ACC_W-1:0] acc_d, acc_q;
  level_t           a_d, a_q, b_d, b_q;
  logic             lvl_err_d, lvl_err_q;

  amp_t             cos_v, sin_v;
  level_t           a1_d, a1_q, b1_d, b1_q;
  logic             v1_d, v1_q;

  logic signed [PROD_W-1:0] pa_d, pa_q, pb_d, pb_q;
  logic                     v2_d, v2_q;

  logic signed [OUT_W-1:0]  qam_d, qam_q;
  logic                     valid_d, valid_q;

  // Phase accumulator, symbol level latch and sticky illegal-code flag.
  always_comb begin
    dec_a     = decode_level(Siga);
    dec_b     = decode_level(Sigb);
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    lvl_err_d = lvl_err_q;
    if (en) begin
      acc_d = acc_q + ACC_W'(PHASE_INC);
    end
    if (sym_stb) begin
      a_d = dec_a.level;
      b_d = dec_b.level;
      if (!dec_a.legal || !dec_b.legal) begin
        lvl_err_d = 1'b1;
      end
`ifdef QAM_PHASE_SYNC_EN
      acc_d = '0;
`else
      acc_d = acc_d;
`endif
    end
  end

  // S1 for the carrier: registered ROM indexed by the accumulator top bits.
  qam_carrier_lut u_lut (
    .clk   (clk),
    .rst   (rst),
    .idx   (acc_q[ACC_W-1 -: 4]),
    .cos_v (cos_v),
    .sin_v (sin_v)
  );

  // Pipeline datapath: S1 level capture, S2 exact products, S3 difference.
  always_comb begin
    a1_d    = a_q;
    b1_d    = b_q;
    v1_d    = en;
    pa_d    = PROD_W'(a1_q) * PROD_W'(cos_v);
    pb_d    = PROD_W'(b1_q) * PROD_W'(sin_v);
    v2_d    = v1_q;
    qam_d   = OUT_W'(pa_q) - OUT_W'(pb_q);
    valid_d = v2_q;
  end

  // All state registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      lvl_err_q <= 1'b0;
      a1_q      <= '0;
      b1_q      <= '0;
      v1_q      <= 1'b0;
      pa_q      <= '0;
      pb_q      <= '0;
      v2_q      <= 1'b0;
      qam_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lvl_err_q <= lvl_err_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      v1_q      <= v1_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      v2_q      <= v2_d;
      qam_q     <= qam_d;
      valid_q   <= valid_d;
    end
  end

  assign qam_out   = qam_q;
  assign out_valid = valid_q;
  assign phase_idx = acc_q[ACC_W-1 -: 4];
  assign lvl_err   = lvl_err_q;

endmodule
